// File: rtl/fifo_burst_sched.sv
// Round-robin write arbiter in front of an external FIFO, plus a burst read
// scheduler that drains the FIFO through a 2-entry skid buffer.
module fifo_burst_sched #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int BURST_LEN  = 16
) (
  input  logic                  clk_tb,
  input  logic                  tb_rst,
  input  logic                  s0_valid,
  input  logic [DATA_WIDTH-1:0] s0_data,
  output logic                  s0_ready,
  input  logic                  s1_valid,
  input  logic [DATA_WIDTH-1:0] s1_data,
  output logic                  s1_ready,
  output logic                  fifo_wr_en,
  output logic [DATA_WIDTH-1:0] fifo_wr_data,
  input  logic                  fifo_full,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty,
  output logic                  burst_req,
  input  logic                  burst_ack,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic                  out_last,
  input  logic                  flush,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  busy
);

  localparam int CW = $clog2(BURST_LEN + 1);
  localparam logic [ADDR_WIDTH:0] LEVEL_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [CW-1:0]       BURST_W   = CW'(BURST_LEN);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_XFER = 2'd2;

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic                  rr_prio;
  logic                  wr_allow;
  logic                  gnt0;
  logic                  gnt1;
  logic                  flush_pend;
  logic [CW-1:0]         burst_cnt;
  logic [CW-1:0]         issued;
  logic [CW-1:0]         accepted;
  logic [DATA_WIDTH-1:0] skid_mem [2];
  logic                  skid_wr_ptr;
  logic                  skid_rd_ptr;
  logic [1:0]            skid_cnt;
  logic                  rd_inflight;
  logic                  skid_room;
  logic                  skid_pop;
  logic                  level_ge_burst;
  logic                  start_burst;
  logic                  end_burst;

  // Grants are gated by reset so ready stays low while tb_rst is held.
  always_comb begin
    wr_allow     = !tb_rst && !fifo_full && (level != LEVEL_MAX);
    gnt0         = wr_allow && s0_valid && (!s1_valid || !rr_prio);
    gnt1         = wr_allow && s1_valid && (!s0_valid || rr_prio);
    s0_ready     = gnt0;
    s1_ready     = gnt1;
    fifo_wr_en   = gnt0 || gnt1;
    fifo_wr_data = gnt0 ? s0_data : (gnt1 ? s1_data : '0);
  end

  always_ff @(posedge clk_tb or posedge tb_rst) begin
    if (tb_rst) begin
      rr_prio <= 1'b0;
    end else if (gnt0) begin
      rr_prio <= 1'b1;
    end else if (gnt1) begin
      rr_prio <= 1'b0;
    end
  end

  always_ff @(posedge clk_tb or posedge tb_rst) begin
    if (tb_rst) begin
      level <= '0;
    end else if (fifo_wr_en && !fifo_rd_en && (level != LEVEL_MAX)) begin
      level <= level + 1'b1;
    end else if (fifo_rd_en && !fifo_wr_en && (level != '0)) begin
      level <= level - 1'b1;
    end
  end

  always_comb begin
    level_ge_burst = (32'(level) >= 32'(BURST_LEN));
    start_burst    = (state == ST_IDLE) && (level_ge_burst || (flush_pend && (level != '0)));
    skid_room      = (({1'b0, rd_inflight} + skid_cnt) < 2'd2);
    fifo_rd_en     = (state == ST_XFER) && (issued < burst_cnt) && !fifo_empty && skid_room;
    out_valid      = (skid_cnt != 2'd0);
    out_data       = skid_mem[skid_rd_ptr];
    out_last       = out_valid && (state == ST_XFER) && ((accepted + CW'(1)) == burst_cnt);
    skid_pop       = out_valid && out_ready;
    end_burst      = (state == ST_XFER) && skid_pop && out_last;
    burst_req      = (state == ST_REQ);
    busy           = (state != ST_IDLE);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start_burst) state_nxt = ST_REQ;
      ST_REQ:  if (burst_ack) state_nxt = ST_XFER;
      ST_XFER: if (end_burst) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_tb or posedge tb_rst) begin
    if (tb_rst) begin
      state     <= ST_IDLE;
      burst_cnt <= '0;
      issued    <= '0;
      accepted  <= '0;
    end else begin
      state <= state_nxt;
      if (start_burst) begin
        burst_cnt <= level_ge_burst ? BURST_W : CW'(level);
        issued    <= '0;
        accepted  <= '0;
      end else begin
        if (fifo_rd_en) issued <= issued + CW'(1);
        if (skid_pop && (state == ST_XFER)) accepted <= accepted + CW'(1);
      end
    end
  end

  // A flush in the same cycle as a burst start stays pending for a later burst.
  always_ff @(posedge clk_tb or posedge tb_rst) begin
    if (tb_rst) begin
      flush_pend <= 1'b0;
    end else if (flush) begin
      flush_pend <= 1'b1;
    end else if (start_burst) begin
      flush_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk_tb or posedge tb_rst) begin
    if (tb_rst) begin
      rd_inflight <= 1'b0;
      skid_wr_ptr <= 1'b0;
      skid_rd_ptr <= 1'b0;
      skid_cnt    <= 2'd0;
      for (int unsigned i = 0; i < 2; i++) skid_mem[i] <= '0;
    end else begin
      rd_inflight <= fifo_rd_en;
      if (rd_inflight) begin
        skid_mem[skid_wr_ptr] <= fifo_rd_data;
        skid_wr_ptr           <= !skid_wr_ptr;
      end
      if (skid_pop) skid_rd_ptr <= !skid_rd_ptr;
      case ({rd_inflight, skid_pop})
        2'b10:   skid_cnt <= skid_cnt + 2'd1;
        2'b01:   skid_cnt <= skid_cnt - 2'd1;
        default: skid_cnt <= skid_cnt;
      endcase
    end
  end

endmodule

// File: doc/fifo_burst_sched.md
FIFO_BURST_SCHED -- requirements
Module: fifo_burst_sched

Interface
REQ-001 Parameter DATA_WIDTH, default 32: data width of the write sources, the FIFO and the output.
REQ-002 Parameter ADDR_WIDTH, default 10: FIFO depth is 2**ADDR_WIDTH, so 1024 words by default.
REQ-003 Parameter BURST_LEN, default 16: words per output burst, range 2..256.
REQ-004 Ports:
- clk_tb  in  1: clock.
- tb_rst  in  1: reset, asynchronous, active-high.
REQ-005 Ports:
- s0_valid  in  1; s0_data  in  DATA_WIDTH; s0_ready  out  1: write source 0.
- s1_valid  in  1; s1_data  in  DATA_WIDTH; s1_ready  out  1: write source 1.
REQ-006 Ports:
- fifo_wr_en  out  1; fifo_wr_data  out  DATA_WIDTH: FIFO write port.
- fifo_full  in  1: FIFO full flag.
REQ-007 Ports:
- fifo_rd_en  out  1: FIFO read enable.
- fifo_rd_data  in  DATA_WIDTH: FIFO read data, valid one cycle after fifo_rd_en.
- fifo_empty  in  1: FIFO empty flag.
REQ-008 Ports:
- burst_req  out  1; burst_ack  in  1: downstream burst grant.
- out_valid  out  1; out_data  out  DATA_WIDTH; out_ready  in  1; out_last  out  1: burst data stream.
REQ-009 Ports:
- flush  in  1: single-cycle pulse requesting a partial burst.
- level  out  ADDR_WIDTH+1: tracked FIFO occupancy.
- busy  out  1: high whenever the read FSM is not in IDLE.

Function
REQ-010 Write arbitration SHALL be round-robin, at most one grant per cycle.
- Grant is allowed only when !fifo_full and level < 2**ADDR_WIDTH.
- After a grant to source N, source 1-N has priority on the next contention.
- Priority after reset: source 0.
REQ-011 sN_ready SHALL be combinational and equal to the grant to source N.
- A transfer occurs when sN_valid && sN_ready.
- On a transfer, fifo_wr_en=1 and fifo_wr_data=sN_data in the same cycle.
REQ-012 level SHALL be updated as follows:
- +1 on fifo_wr_en alone.
- -1 on fifo_rd_en alone.
- Unchanged when both are asserted in the same cycle.
- Never wraps; level ranges 0..2**ADDR_WIDTH.
REQ-013 The read FSM SHALL have states IDLE, REQ and XFER.
REQ-014 IDLE -> REQ SHALL occur when level >= BURST_LEN, or when a flush is pending and level > 0.
- On that transition, burst_cnt is latched to min(level, BURST_LEN).
REQ-015 In REQ, burst_req SHALL be held at 1 until burst_ack is sampled high; then the FSM goes to XFER.
- burst_req=0 in every other state.
REQ-016 In XFER, fifo_rd_en SHALL be asserted only when all three hold:
- issued < burst_cnt;
- !fifo_empty;
- (skid occupancy + reads in flight) < 2.
REQ-017 Returning read data SHALL enter a 2-entry skid buffer.
- out_valid is high whenever the buffer is non-empty.
- out_data is the head entry.
- An entry pops when out_valid && out_ready.
REQ-018 out_valid and out_data SHALL stay stable while out_valid && !out_ready.
REQ-019 out_last SHALL be 1 exactly on the burst_cnt-th word of the burst.
- XFER -> IDLE occurs on the cycle that word is accepted.
REQ-020 A flush pulse SHALL set a pending flag.
- The flag clears when the FSM enters REQ.
- A flush arriving while busy remains pending.
- A flush with level == 0 is held until data arrives.
REQ-021 Bursts SHALL NOT overlap.
- Leaving XFER requires issued == burst_cnt and the skid buffer empty.
- The FSM may re-enter REQ on the cycle after returning to IDLE.

Reset
REQ-022 While tb_rst is high, all of the following SHALL hold:
- Outputs: s0_ready=0, s1_ready=0, fifo_wr_en=0, fifo_wr_data=0, fifo_rd_en=0, burst_req=0, out_valid=0, out_data=0, out_last=0, level=0, busy=0.
- State: FSM=IDLE, flush pending cleared, skid buffer and counters cleared, round-robin priority = source 0.
REQ-023 A reset asserted mid-burst SHALL abort the burst immediately.
- The FIFO is reset by the same tb_rst, so level=0 remains consistent.

Verification
REQ-024 s0 alone writes 16 words (values 1..16), burst_ack is tied high, out_ready=1 -> out_data 1..16 in order; out_last on the word 16; level returns to 0.
REQ-025 s0 and s1 are both valid continuously for 8 cycles -> grants alternate s0,s1,s0,...; each source has 4 words accepted.
REQ-026 Write 1024 words -> level=1024, s0_ready=0 and s1_ready=0 while s0_valid/s1_valid=1; no grant while fifo_full=1.
REQ-027 Write 5 words, then pulse flush -> one burst of 5 words; out_last on the word 5; FSM returns to IDLE.
REQ-028 Mid-burst, out_ready=0 for 3 cycles -> out_data is held stable; at most 2 reads in flight or buffered; no word lost or duplicated.
REQ-029 Assert tb_rst after 7 of 16 words in XFER -> all outputs and level are 0 within the reset; after release, the FSM is in IDLE.
